// File: rtl/triad_pkg.sv
// Shared types and helpers for the triad decoder: decoder FSM states,
// half-strips per triad, and the one-hot half-strip encoder.
package triad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIT_A = 2'd1,
    BIT_B = 2'd2
  } triad_state_t;

  localparam int HS_PER_TRIAD = 4;

  function automatic logic [HS_PER_TRIAD-1:0] hs_onehot(input logic a, input logic b);
    logic [HS_PER_TRIAD-1:0] v;
    v        = '0;
    v[{a, b}] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/triad_decode_ch.sv
// One triad channel: start/strip/half-strip deserialiser, hit hold stage and
// skip pulse. Optional saturating skip counter under TRIAD_SKIP_CNT_EN.
module triad_decode_ch
  import triad_pkg::*;
#(
  parameter int PERSIST_W = 4
`ifdef TRIAD_SKIP_CNT_EN
  , parameter int CNT_W   = 8
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PERSIST_W-1:0]    persist_i,
  input  logic                    persist1_i,
  input  logic                    triad_i,
  output logic [HS_PER_TRIAD-1:0] h_strip_o,
  output logic                    triad_skip_o
`ifdef TRIAD_SKIP_CNT_EN
  , output logic [CNT_W-1:0]      skip_cnt_o
`endif
);

  localparam int HOLD_W = PERSIST_W + 1;

  triad_state_t             state_q, state_d;
  logic                     a_q, a_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [HS_PER_TRIAD-1:0]  hs_q, hs_d;
  logic                     skip_q, skip_d;
  logic                     complete;
  logic [HOLD_W-1:0]        len;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE:    if (triad_i) state_d = BIT_A;
      BIT_A: begin
        a_d     = triad_i;
        state_d = BIT_B;
      end
      BIT_B: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (persist1_i || (persist_i == '0)) len = HOLD_W'(1);
    else                                 len = HOLD_W'(persist_i);
  end

  // A triad finishing in the last hold cycle replaces the hit with no gap;
  // a dropped triad still lets the running hold count down.
  always_comb begin
    hs_d   = hs_q;
    hold_d = hold_q;
    skip_d = 1'b0;
    if (complete && (hold_q <= HOLD_W'(1))) begin
      hs_d   = hs_onehot(a_q, triad_i);
      hold_d = len;
    end else begin
      skip_d = complete;
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HOLD_W'(1)) hs_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      hold_q  <= '0;
      hs_q    <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hold_q  <= hold_d;
      hs_q    <= hs_d;
      skip_q  <= skip_d;
    end
  end

  assign h_strip_o    = hs_q;
  assign triad_skip_o = skip_q;

`ifdef TRIAD_SKIP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (skip_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign skip_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/triad_decode_array.sv
// NCH independent triad decoders with shared persistence controls.
// Define TRIAD_SKIP_CNT_EN to add per-channel saturating skip counters.
module triad_decode_array
  import triad_pkg::*;
#(
  parameter int NCH       = 6,
  parameter int PERSIST_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PERSIST_W-1:0]        persist,
  input  logic                        persist1,
  input  logic [NCH-1:0]              ch_en,
  input  logic [NCH-1:0]              triad,
  output logic [HS_PER_TRIAD*NCH-1:0] h_strip,
  output logic [NCH-1:0]              triad_skip
`ifdef TRIAD_SKIP_CNT_EN
  , output logic [CNT_W*NCH-1:0]      skip_cnt
`endif
);

  if ((PERSIST_W < 1) || (CNT_W < 1)) begin : g_bad_param
    $error("triad_decode_array: PERSIST_W and CNT_W must be at least 1");
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    // A disabled channel sits in the same state as a reset one.
    logic ch_rst;
    assign ch_rst = reset | ~ch_en[n];

    triad_decode_ch #(
      .PERSIST_W (PERSIST_W)
`ifdef TRIAD_SKIP_CNT_EN
      , .CNT_W   (CNT_W)
`endif
    ) u_ch (
      .clk_i        (clock),
      .rst_i        (ch_rst),
      .persist_i    (persist),
      .persist1_i   (persist1),
      .triad_i      (triad[n]),
      .h_strip_o    (h_strip[HS_PER_TRIAD*n +: HS_PER_TRIAD]),
      .triad_skip_o (triad_skip[n])
`ifdef TRIAD_SKIP_CNT_EN
      , .skip_cnt_o (skip_cnt[CNT_W*n +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_triad_decode_array.sv
// Directed bench for triad_decode_array: expected outputs are queued as each
// triad bit is driven and compared just after the following clock edge.
module tb_triad_decode_array;

  localparam int NCH       = 6;
  localparam int PERSIST_W = 4;
  localparam int CNT_W     = 8;
  localparam int HW        = 4 * NCH;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [PERSIST_W-1:0]  persist;
  logic                  persist1;
  logic [NCH-1:0]        ch_en;
  logic [NCH-1:0]        triad;
  logic [HW-1:0]         h_strip;
  logic [NCH-1:0]        triad_skip;
`ifdef TRIAD_SKIP_CNT_EN
  logic [CNT_W*NCH-1:0]  skip_cnt;
`endif

  triad_decode_array #(
    .NCH       (NCH),
    .PERSIST_W (PERSIST_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .persist    (persist),
    .persist1   (persist1),
    .ch_en      (ch_en),
    .triad      (triad),
    .h_strip    (h_strip),
    .triad_skip (triad_skip)
`ifdef TRIAD_SKIP_CNT_EN
    , .skip_cnt (skip_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [HW-1:0]  h;
    logic [NCH-1:0] s;
    string          tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [HW-1:0] hv(input int ch, input logic [3:0] nib);
    logic [HW-1:0] v;
    v             = '0;
    v[4*ch +: 4]  = nib;
    return v;
  endfunction

  // Drive one triad sample, queue what must be visible after the edge, then
  // pop and compare 1 time unit after that edge.
  task automatic cyc(input logic [NCH-1:0] t, input logic [HW-1:0] eh,
                     input logic [NCH-1:0] es, input string tag);
    exp_t e;
    exp_t got;
    triad = t;
    e.h   = eh;
    e.s   = es;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    n_assert++;
    assert (h_strip === got.h) else begin
      n_fail++;
      $error("FAIL %s h_strip observed=%h expected=%h", got.tag, h_strip, got.h);
    end
    n_assert++;
    assert (triad_skip === got.s) else begin
      n_fail++;
      $error("FAIL %s triad_skip observed=%b expected=%b", got.tag, triad_skip, got.s);
    end
  endtask

`ifdef TRIAD_SKIP_CNT_EN
  task automatic chk_cnt(input logic [CNT_W-1:0] exp0, input string tag);
    n_assert++;
    assert (skip_cnt[CNT_W-1:0] === exp0) else begin
      n_fail++;
      $error("FAIL %s skip_cnt0 observed=%0d expected=%0d", tag, skip_cnt[CNT_W-1:0], exp0);
    end
  endtask
`endif

  logic s4 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    reset    = 1'b1;
    ch_en    = '1;
    triad    = '0;
    persist  = 4'd4;
    persist1 = 1'b0;

    // Reset state
    cyc('0, '0, '0, "rst_a");
    cyc('0, '0, '0, "rst_b");
`ifdef TRIAD_SKIP_CNT_EN
    chk_cnt(8'd0, "rst_cnt");
`endif
    reset = 1'b0;

    // Single triad 1,1,0 -> hs2, held 4 clocks
    cyc(6'h01, '0, '0, "t1_e0");
    cyc(6'h01, '0, '0, "t1_e1");
    cyc(6'h00, hv(0, 4'b0100), '0, "t1_e2");
    for (int i = 0; i < 3; i++) cyc(6'h00, hv(0, 4'b0100), '0, "t1_hold");
    cyc(6'h00, '0, '0, "t1_clear");
    cyc(6'h00, '0, '0, "t1_idle");

    // hs1 with persist 8, then 1,1,1 dropped at E5
    persist = 4'd8;
    cyc(6'h01, '0, '0, "t2_e0");
    cyc(6'h00, '0, '0, "t2_e1");
    cyc(6'h01, hv(0, 4'b0010), '0, "t2_e2");
    cyc(6'h01, hv(0, 4'b0010), '0, "t2_e3");
    cyc(6'h01, hv(0, 4'b0010), '0, "t2_e4");
    cyc(6'h01, hv(0, 4'b0010), 6'h01, "t2_drop");
`ifdef TRIAD_SKIP_CNT_EN
    chk_cnt(8'd1, "t2_cnt");
`endif
    for (int i = 0; i < 4; i++) cyc(6'h00, hv(0, 4'b0010), '0, "t2_hold");
    cyc(6'h00, '0, '0, "t2_clear");

    // Back-to-back with persist 3: hs0 then hs3, no gap
    persist = 4'd3;
    cyc(6'h01, '0, '0, "t3_e0");
    cyc(6'h00, '0, '0, "t3_e1");
    cyc(6'h00, hv(0, 4'b0001), '0, "t3_e2");
    cyc(6'h01, hv(0, 4'b0001), '0, "t3_e3");
    cyc(6'h01, hv(0, 4'b0001), '0, "t3_e4");
    cyc(6'h01, hv(0, 4'b1000), '0, "t3_e5");
    cyc(6'h00, hv(0, 4'b1000), '0, "t3_hold");
    cyc(6'h00, hv(0, 4'b1000), '0, "t3_hold");
    cyc(6'h00, '0, '0, "t3_clear");

    // persist1 forces 1-clock hits despite persist 15
    persist  = 4'd15;
    persist1 = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc({5'b0, s4[i]}, ((i == 5) || (i == 9)) ? hv(0, 4'b1000) : '0, '0, "t4_p1");
    cyc(6'h00, '0, '0, "t4_after");

    // ch2 hs2 decodes while disabled ch5 ignores its triad
    persist1 = 1'b0;
    persist  = 4'd2;
    ch_en    = 6'b011111;
    cyc(6'h24, '0, '0, "t5_e0");
    cyc(6'h24, '0, '0, "t5_e1");
    cyc(6'h20, hv(2, 4'b0100), '0, "t5_ch2");
    cyc(6'h00, hv(2, 4'b0100), '0, "t5_hold");
    cyc(6'h00, '0, '0, "t5_clear");

    // Disabling ch5 mid-triad aborts it
    ch_en = '1;
    cyc(6'h20, '0, '0, "t5_ab0");
    ch_en = 6'b011111;
    cyc(6'h20, '0, '0, "t5_ab1");
    ch_en = '1;
    cyc(6'h00, '0, '0, "t5_ab2");
    cyc(6'h00, '0, '0, "t5_ab3");

    // Re-enabled ch5 decodes hs3
    cyc(6'h20, '0, '0, "t5_r0");
    cyc(6'h20, '0, '0, "t5_r1");
    cyc(6'h20, hv(5, 4'b1000), '0, "t5_ch5");
    cyc(6'h00, hv(5, 4'b1000), '0, "t5_ch5_hold");
    cyc(6'h00, '0, '0, "t5_ch5_clear");

    // Reset at E1 aborts the triad
    persist = 4'd4;
    cyc(6'h01, '0, '0, "t6_e0");
    reset = 1'b1;
    cyc(6'h01, '0, '0, "t6_rst");
    reset = 1'b0;
    cyc(6'h00, '0, '0, "t6_post0");
    cyc(6'h00, '0, '0, "t6_post1");
    cyc(6'h00, '0, '0, "t6_post2");
`ifdef TRIAD_SKIP_CNT_EN
    chk_cnt(8'd0, "t6_cnt");
`endif

    // First sample after reset is a start bit; reset during hold clears hit
    reset = 1'b1;
    cyc(6'h00, '0, '0, "t6_rst2");
    reset = 1'b0;
    cyc(6'h01, '0, '0, "t6_s0");
    cyc(6'h01, '0, '0, "t6_s1");
    cyc(6'h01, hv(0, 4'b1000), '0, "t6_hit");
    cyc(6'h00, hv(0, 4'b1000), '0, "t6_hit_hold");
    reset = 1'b1;
    cyc(6'h00, '0, '0, "t6_rst_hold");
    reset = 1'b0;
    cyc(6'h00, '0, '0, "t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
